// File: rtl/microsequencer.sv
// Microstate sequencer for the microprogrammed ARM control unit: picks the next
// control-ROM address and handles MOC waits with timeout.
module microsequencer #(
  parameter logic [6:0]  FETCH_STATE = 7'd1,
  parameter logic [6:0]  RESET_STATE = 7'd0,
  parameter int unsigned MOC_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [6:0] enc_state,
  input  logic       cond_ok,
  input  logic       moc,
  input  logic [2:0] ns_sel,
  input  logic [6:0] cr_addr,
  input  logic       inv,
  input  logic       hold,
  output logic [6:0] state,
  output logic       undef,
  output logic       mem_timeout
);

  typedef enum logic [2:0] {
    SEL_DISPATCH  = 3'd0,
    SEL_INC       = 3'd1,
    SEL_JUMP      = 3'd2,
    SEL_WAIT_MOC  = 3'd3,
    SEL_COND_JUMP = 3'd4,
    SEL_RETURN    = 3'd5
  } sel_e;

  localparam logic [7:0] WAIT_LAST = 8'(MOC_TIMEOUT - 1);

  logic [7:0] wait_cnt;
  logic [7:0] next_cnt;
  logic [6:0] next_state;
  logic [6:0] state_inc;
  logic       next_undef;
  logic       set_timeout;
  logic       moc_seen;

  assign state_inc = state + 7'd1;
  assign moc_seen  = moc ^ inv;

  // Counter defaults to cleared so any select other than WAIT_MOC restarts the wait.
  always_comb begin
    next_state  = state;
    next_cnt    = '0;
    next_undef  = 1'b0;
    set_timeout = 1'b0;
    case (sel_e'(ns_sel))
      SEL_DISPATCH: begin
        if (!cond_ok) begin
          next_state = FETCH_STATE;
        end else if (enc_state == FETCH_STATE) begin
          next_state = FETCH_STATE;
          next_undef = 1'b1;
        end else begin
          next_state = enc_state;
        end
      end
      SEL_INC:  next_state = state_inc;
      SEL_JUMP: next_state = cr_addr;
      SEL_WAIT_MOC: begin
        if (moc_seen) begin
          next_state = state_inc;
        end else if (wait_cnt == WAIT_LAST) begin
          next_state  = FETCH_STATE;
          set_timeout = 1'b1;
        end else begin
          next_cnt = wait_cnt + 8'd1;
        end
      end
      SEL_COND_JUMP: next_state = cond_ok ? cr_addr : state_inc;
      SEL_RETURN:    next_state = FETCH_STATE;
      default: begin
        next_state = FETCH_STATE;
        next_undef = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state       <= RESET_STATE;
      wait_cnt    <= '0;
      undef       <= 1'b0;
      mem_timeout <= 1'b0;
    end else if (hold) begin
      undef <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
      undef    <= next_undef;
      if (set_timeout) mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Scoreboard bench for microsequencer: a reference model pushes expected
// state/undef/mem_timeout per cycle, popped and compared after the edge.
module tb_microsequencer;

  localparam int unsigned TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       clr;
  logic [6:0] enc_state;
  logic       cond_ok;
  logic       moc;
  logic [2:0] ns_sel;
  logic [6:0] cr_addr;
  logic       inv;
  logic       hold;
  logic [6:0] state;
  logic       undef;
  logic       mem_timeout;

  microsequencer #(
    .FETCH_STATE(7'd1),
    .RESET_STATE(7'd0),
    .MOC_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .clr(clr), .enc_state(enc_state), .cond_ok(cond_ok),
    .moc(moc), .ns_sel(ns_sel), .cr_addr(cr_addr), .inv(inv), .hold(hold),
    .state(state), .undef(undef), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] st;
    logic       ud;
    logic       to;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [6:0] m_state;
  logic [7:0] m_cnt;
  logic       m_undef;
  logic       m_to;

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 7'd0;
    m_cnt   = 8'd0;
    m_undef = 1'b0;
    m_to    = 1'b0;
  endtask

  // One clock: drive inputs, predict the post-edge outputs, then compare after the edge.
  task automatic cycle(input logic [2:0] sel, input logic [6:0] enc, input logic [6:0] cr,
                       input logic c, input logic mo, input logic iv, input logic h,
                       input string tag);
    logic [6:0] ns;
    logic [7:0] nc;
    logic       nu;
    exp_t       e;
    exp_t       got;
    ns_sel = sel; enc_state = enc; cr_addr = cr; cond_ok = c; moc = mo; inv = iv; hold = h;
    ns = m_state; nc = 8'd0; nu = 1'b0;
    if (h) begin
      nc = m_cnt;
    end else begin
      case (sel)
        3'd0: if (!c) ns = 7'd1;
              else if (enc == 7'd1) begin ns = 7'd1; nu = 1'b1; end
              else ns = enc;
        3'd1: ns = m_state + 7'd1;
        3'd2: ns = cr;
        3'd3: if (mo != iv) ns = m_state + 7'd1;
              else if (m_cnt == 8'(TIMEOUT - 1)) begin ns = 7'd1; m_to = 1'b1; end
              else nc = m_cnt + 8'd1;
        3'd4: ns = c ? cr : m_state + 7'd1;
        3'd5: ns = 7'd1;
        default: begin ns = 7'd1; nu = 1'b1; end
      endcase
    end
    m_state = ns; m_cnt = nc; m_undef = nu;
    e.st = m_state; e.ud = m_undef; e.to = m_to; e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check({got.tag, ".state"}, state, got.st);
    check({got.tag, ".undef"}, undef, got.ud);
    check({got.tag, ".mem_timeout"}, mem_timeout, got.to);
  endtask

  task automatic idle_inputs();
    ns_sel = 3'd5; enc_state = '0; cr_addr = '0; cond_ok = 1'b0;
    moc = 1'b0; inv = 1'b0; hold = 1'b0;
  endtask

  // Asserts clr between edges and checks the outputs respond before any clock edge.
  task automatic async_reset(input string tag);
    #2;
    clr = 1'b0;
    #1;
    check({tag, ".state"}, state, 0);
    check({tag, ".undef"}, undef, 0);
    check({tag, ".mem_timeout"}, mem_timeout, 0);
    model_reset();
    @(negedge clk);
    clr = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.state", state, 0);
    check("reset.undef", undef, 0);
    check("reset.mem_timeout", mem_timeout, 0);
    @(negedge clk);
    clr = 1'b1;

    cycle(3'd2, 7'd0, 7'd40, 1'b0, 1'b0, 1'b0, 1'b0, "jump40");
    check("at40", state, 40);
    async_reset("midreset");

    cycle(3'd0, 7'd14, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, "disp14");
    cycle(3'd0, 7'd14, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, "disp_skip");
    cycle(3'd0, 7'd1,  7'd0, 1'b1, 1'b0, 1'b0, 1'b0, "disp_unsup");
    check("unsup_pulse", undef, 1);
    cycle(3'd1, 7'd0,  7'd0, 1'b0, 1'b0, 1'b0, 1'b0, "after_unsup");
    cycle(3'd0, 7'd1,  7'd0, 1'b1, 1'b0, 1'b0, 1'b0, "b2b_unsup0");
    cycle(3'd0, 7'd1,  7'd0, 1'b1, 1'b0, 1'b0, 1'b0, "b2b_unsup1");
    cycle(3'd1, 7'd0,  7'd0, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_end");

    cycle(3'd2, 7'd0, 7'd126, 1'b0, 1'b0, 1'b0, 1'b0, "jump126");
    cycle(3'd1, 7'd0, 7'd0,   1'b0, 1'b0, 1'b0, 1'b0, "inc127");
    cycle(3'd1, 7'd0, 7'd0,   1'b0, 1'b0, 1'b0, 1'b0, "wrap0");
    check("wrap_zero", state, 0);

    cycle(3'd4, 7'd0, 7'd93, 1'b1, 1'b0, 1'b0, 1'b0, "cjump_taken");
    cycle(3'd2, 7'd0, 7'd50, 1'b0, 1'b0, 1'b0, 1'b0, "jump50");
    cycle(3'd4, 7'd0, 7'd93, 1'b0, 1'b0, 1'b0, 1'b0, "cjump_fall");

    cycle(3'd2, 7'd0, 7'd37, 1'b0, 1'b0, 1'b0, 1'b0, "jump37");
    for (int i = 0; i < 5; i++)
      cycle(3'd3, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, "moc_wait");
    cycle(3'd3, 7'd0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, "moc_done");
    check("moc_adv38", state, 38);
    cycle(3'd3, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0, "moc_inv");

    cycle(3'd2, 7'd0, 7'd20, 1'b0, 1'b0, 1'b0, 1'b0, "jump20");
    for (int i = 0; i < 16; i++)
      cycle(3'd3, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, "timeout_wait");
    check("timeout_fetch", state, 1);
    cycle(3'd2, 7'd0, 7'd9, 1'b0, 1'b0, 1'b0, 1'b0, "sticky_jump");
    cycle(3'd0, 7'd14, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, "sticky_disp");
    check("timeout_sticky", mem_timeout, 1);
    async_reset("clr_timeout");

    cycle(3'd2, 7'd0, 7'd20, 1'b0, 1'b0, 1'b0, 1'b0, "jump20b");
    for (int i = 0; i < 15; i++)
      cycle(3'd3, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, "edge_wait");
    cycle(3'd3, 7'd0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, "edge_moc_wins");

    cycle(3'd2, 7'd0, 7'd60, 1'b0, 1'b0, 1'b0, 1'b0, "jump60");
    for (int i = 0; i < 5; i++)
      cycle(3'd3, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, "hold_pre");
    for (int i = 0; i < 3; i++)
      cycle(3'd3, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, "hold_frozen");
    for (int i = 0; i < 11; i++)
      cycle(3'd3, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, "hold_post");
    check("hold_timeout", mem_timeout, 1);
    async_reset("clr_hold");

    cycle(3'd0, 7'd1, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, "undef_then_hold");
    cycle(3'd6, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, "hold_kills_undef");
    cycle(3'd6, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reserved6");
    cycle(3'd7, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reserved7");
    cycle(3'd5, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, "return");

    for (int i = 0; i < 300; i++) begin
      logic [2:0] s;
      logic [6:0] en;
      s  = 3'($urandom_range(0, 7));
      en = ($urandom_range(0, 3) == 0) ? 7'd1 : 7'($urandom);
      cycle(s, en, 7'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0), "random");
    end

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
